// File: rtl/xor_checksum_stream.sv
// -----------------------------------------------------------------------------
// xor_checksum_stream
//
// Streaming XOR checksum. Words arrive over a valid/ready stream and are
// folded into a running XOR. The packet ends on the word tagged with up_last.
// One cycle after that word is accepted, the result is presented in a
// one-entry output register with valid/ready backpressure. The result is the
// checksum, its reduction parity and a length-error flag.
//
// Optional feature macro: XOR_CHECKSUM_STREAM_COUNT_EN
//   When defined, the port down_count is added. It reports the saturated word
//   count of the packet being reported.
//
// Parameters:
//   WIDTH      data and checksum width in bits (>= 1)
//   MAX_WORDS  longest legal packet in words (>= 1)
//
// Ports:
//   clk          clock; all state updates on the rising edge
//   rst_n        asynchronous active-low reset
//   up_valid     upstream word valid
//   up_ready     block can accept a word this cycle
//   up_data      upstream word
//   up_last      marks the final word of a packet
//   down_valid   checksum result valid
//   down_ready   sink accepts the result
//   down_sum     XOR of all words of the packet
//   down_parity  reduction XOR of down_sum
//   down_err     packet was longer than MAX_WORDS words
//   down_count   (optional) saturated word count of the reported packet
// -----------------------------------------------------------------------------
module xor_checksum_stream #(
    parameter int WIDTH     = 8,
    parameter int MAX_WORDS = 16,
    localparam int CW       = $clog2(MAX_WORDS + 2)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [WIDTH-1:0] up_data,
    input  logic             up_last,
    output logic             down_valid,
    input  logic             down_ready,
    output logic [WIDTH-1:0] down_sum,
    output logic             down_parity,
`ifdef XOR_CHECKSUM_STREAM_COUNT_EN
    output logic             down_err,
    output logic [CW-1:0]    down_count
`else
    output logic             down_err
`endif
);

    // The count stops one step past the legal maximum. That is enough to flag
    // an over-length packet, and the counter can never wrap.
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WORDS);
    localparam logic [CW-1:0] SAT_CNT = CW'(MAX_WORDS + 1);

    typedef enum logic {
        IDLE,
        ACC
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] acc_nxt;
    logic [CW-1:0]    count_nxt;
    logic             up_xfer;
    logic             down_xfer;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        return (c >= SAT_CNT) ? c : c + CW'(1);
    endfunction

    // A pending result that drains this cycle frees the slot immediately.
    // Because of this, a new word can be taken in the same cycle.
    assign up_ready  = !down_valid || down_ready;
    assign up_xfer   = up_valid && up_ready;
    assign down_xfer = down_valid && down_ready;

    // The first word of a packet replaces the accumulator instead of merging
    // into it. This way no residue from an earlier packet can leak in.
    always_comb begin
        acc_nxt   = up_data;
        count_nxt = CW'(1);
        if (state == ACC) begin
            acc_nxt   = acc ^ up_data;
            count_nxt = sat_inc(count);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            acc         <= '0;
            count       <= '0;
            down_valid  <= 1'b0;
            down_sum    <= '0;
            down_parity <= 1'b0;
            down_err    <= 1'b0;
`ifdef XOR_CHECKSUM_STREAM_COUNT_EN
            down_count  <= '0;
`endif
        end else begin
            // accumulate stage
            if (up_xfer) begin
                acc   <= acc_nxt;
                count <= count_nxt;
                state <= up_last ? IDLE : ACC;
            end

            // output register stage: a new completion overrides a drain, so
            // back-to-back results keep down_valid high without a bubble
            if (up_xfer && up_last) begin
                down_valid  <= 1'b1;
                down_sum    <= acc_nxt;
                down_parity <= ^acc_nxt;
                down_err    <= (count_nxt > MAX_CNT);
`ifdef XOR_CHECKSUM_STREAM_COUNT_EN
                down_count  <= count_nxt;
`endif
            end else if (down_xfer) begin
                down_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_xor_checksum_stream.sv
module tb_xor_checksum_stream;

    localparam int WIDTH     = 8;
    localparam int MAX_WORDS = 16;
    localparam int CW        = $clog2(MAX_WORDS + 2);

    logic             clk;
    logic             rst_n;
    logic             up_valid;
    logic             up_ready;
    logic [WIDTH-1:0] up_data;
    logic             up_last;
    logic             down_valid;
    logic             down_ready;
    logic [WIDTH-1:0] down_sum;
    logic             down_parity;
    logic             down_err;
`ifdef XOR_CHECKSUM_STREAM_COUNT_EN
    logic [CW-1:0]    down_count;
`endif

    xor_checksum_stream #(
        .WIDTH    (WIDTH),
        .MAX_WORDS(MAX_WORDS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .up_valid   (up_valid),
        .up_ready   (up_ready),
        .up_data    (up_data),
        .up_last    (up_last),
        .down_valid (down_valid),
        .down_ready (down_ready),
        .down_sum   (down_sum),
        .down_parity(down_parity),
`ifdef XOR_CHECKSUM_STREAM_COUNT_EN
        .down_err   (down_err),
        .down_count (down_count)
`else
        .down_err   (down_err)
`endif
    );

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             par;
        logic             err;
        logic [CW-1:0]    cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic expect_pkt(input logic [WIDTH-1:0] s, input logic p, input logic e,
                              input logic [CW-1:0] c);
        exp_t x;
        x.sum = s;
        x.par = p;
        x.err = e;
        x.cnt = c;
        exp_q.push_back(x);
    endtask

    // Inputs change 2 time units after the rising edge. At the falling edge
    // both the inputs and the outputs are stable, so a transfer seen there
    // happens on the next rising edge.
    always @(negedge clk) begin
        if (rst_n && down_valid && down_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 32'(down_sum), 32'hFFFF_FFFF);
            end else begin
                exp_t x;
                x = exp_q.pop_front();
                chk("down_sum", 32'(down_sum), 32'(x.sum));
                chk("down_parity", 32'(down_parity), 32'(x.par));
                chk("down_err", 32'(down_err), 32'(x.err));
`ifdef XOR_CHECKSUM_STREAM_COUNT_EN
                chk("down_count", 32'(down_count), 32'(x.cnt));
`endif
            end
        end
    end

    task automatic send(input logic [WIDTH-1:0] d, input logic l);
        int n;
        up_valid = 1'b1;
        up_data  = d;
        up_last  = l;
        n = 0;
        @(negedge clk);
        while (!up_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!up_ready) chk("send_timeout", 32'(up_ready), 32'd1);
        @(posedge clk);
        #2;
        up_valid = 1'b0;
        up_last  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n      = 1'b0;
        up_valid   = 1'b0;
        up_data    = '0;
        up_last    = 1'b0;
        down_ready = 1'b1;

        // reset state
        #12;
        chk("rst_down_valid", 32'(down_valid), 32'd0);
        chk("rst_down_sum", 32'(down_sum), 32'd0);
        chk("rst_down_parity", 32'(down_parity), 32'd0);
        chk("rst_down_err", 32'(down_err), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        chk("rst_up_ready", 32'(up_ready), 32'd1);

        // single-word packet
        expect_pkt(8'hA5, 1'b0, 1'b0, CW'(1));
        send(8'hA5, 1'b1);
        chk("single_valid", 32'(down_valid), 32'd1);
        @(posedge clk); #2;
        chk("single_drain", 32'(down_valid), 32'd0);

        // 3-word packet with idle gaps
        expect_pkt(8'hC3, 1'b0, 1'b0, CW'(3));
        send(8'h0F, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        chk("gap_no_valid", 32'(down_valid), 32'd0);
        send(8'hF0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        send(8'h3C, 1'b1);
        chk("three_valid", 32'(down_valid), 32'd1);
        @(posedge clk); #2;
        chk("three_one_pulse", 32'(down_valid), 32'd0);

        // back-to-back single-word packets
        expect_pkt(8'h01, 1'b1, 1'b0, CW'(1));
        expect_pkt(8'h03, 1'b0, 1'b0, CW'(1));
        send(8'h01, 1'b1);
        chk("b2b_first_valid", 32'(down_valid), 32'd1);
        send(8'h03, 1'b1);
        chk("b2b_second_valid", 32'(down_valid), 32'd1);
        chk("b2b_second_sum", 32'(down_sum), 32'h03);
        @(posedge clk); #2;
        chk("b2b_drain", 32'(down_valid), 32'd0);

        // backpressure
        down_ready = 1'b0;
        expect_pkt(8'h77, 1'b0, 1'b0, CW'(1));
        send(8'h77, 1'b1);
        up_valid = 1'b1;
        up_data  = 8'h11;
        up_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_up_ready", 32'(up_ready), 32'd0);
            chk("bp_valid", 32'(down_valid), 32'd1);
            chk("bp_sum_stable", 32'(down_sum), 32'h77);
        end
        @(posedge clk); #2;
        expect_pkt(8'h11, 1'b0, 1'b0, CW'(1));
        down_ready = 1'b1;
        #1 chk("bp_release_ready", 32'(up_ready), 32'd1);
        @(posedge clk); #2;
        up_valid = 1'b0;
        up_last  = 1'b0;
        chk("bp_new_valid", 32'(down_valid), 32'd1);
        chk("bp_new_sum", 32'(down_sum), 32'h11);
        @(posedge clk); #2;

        // overflow: 17 words, then a legal 2-word packet
        expect_pkt(8'h01, 1'b1, 1'b1, CW'(17));
        for (int i = 0; i < 17; i++) send(8'h01, (i == 16));
        expect_pkt(8'h00, 1'b0, 1'b0, CW'(2));
        send(8'h01, 1'b0);
        send(8'h01, 1'b1);
        @(posedge clk); #2;

        // reset with a result pending
        send(8'hAA, 1'b0);
        send(8'h0F, 1'b0);
        down_ready = 1'b0;
        send(8'h3C, 1'b1);
        chk("pend_valid", 32'(down_valid), 32'd1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_pend_valid", 32'(down_valid), 32'd0);
        chk("arst_pend_sum", 32'(down_sum), 32'd0);
        down_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // reset mid-packet, then a clean packet
        send(8'hAA, 1'b0);
        send(8'h0F, 1'b0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk("arst_mid_valid", 32'(down_valid), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        expect_pkt(8'h55, 1'b0, 1'b0, CW'(1));
        send(8'h55, 1'b1);

        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
